// File: rtl/mem_berger_pkg.sv
// Shared types and Berger-code helpers for the zero-count protected memory.
package mem_berger_pkg;

  localparam int unsigned BERGER_MAX_W      = 64;
  localparam int unsigned BERGER_WORD_MAX_W = 128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } scrub_state_e;

  // Number of zero bits in the low data_w bits of data.
  function automatic int unsigned berger_zeros(input logic [BERGER_MAX_W-1:0] data,
                                               input int unsigned data_w);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < BERGER_MAX_W; i++) begin
      if (i < data_w && !data[i]) n++;
    end
    return n;
  endfunction

  // All-zero data with its matching check field {data_w, 0}.
  function automatic logic [BERGER_WORD_MAX_W-1:0] berger_reset_word(input int unsigned data_w);
    return BERGER_WORD_MAX_W'(data_w) << data_w;
  endfunction

endpackage

// File: rtl/berger_zero_chk.sv
// Combinational Berger check: flags a codeword whose check field differs from the data zero count.
module berger_zero_chk
  import mem_berger_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CHK_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [CHK_W-1:0]  chk,
  output logic              err_c
);

  assign err_c = CHK_W'(berger_zeros(BERGER_MAX_W'(data), DATA_W)) != chk;

endmodule

// File: rtl/mem_berger_zero_scrub.sv
// Berger-protected register-file memory with host read checking, idle-cycle scrub and error log.
module mem_berger_zero_scrub
  import mem_berger_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned CHK_W  = $clog2(DATA_W + 1),
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [DATA_W+CHK_W-1:0] inj_mask,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  input  logic                    scrub_start,
  output logic                    scrub_busy,
  output logic                    scrub_done,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [ADDR_W-1:0]       err_addr,
  output logic                    err_src,
  output logic                    err_irq,
  input  logic                    err_clr
);

  localparam int unsigned       WORD_W   = DATA_W + CHK_W;
  localparam logic [WORD_W-1:0] RST_WORD = WORD_W'(berger_reset_word(DATA_W));
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] host_word;
  logic [WORD_W-1:0] scrub_word;
  logic [WORD_W-1:0] wr_word_c;
  logic              host_err_c;
  logic              scrub_err_c;
  logic              host_rd_c;
  logic              scrub_chk_c;
  logic              host_trig_c;
  logic              scrub_trig_c;

  scrub_state_e      state;
  logic [ADDR_W-1:0] scrub_ptr;

  assign host_word    = mem[req_addr];
  assign scrub_word   = mem[scrub_ptr];
  assign wr_word_c    = {CHK_W'(berger_zeros(BERGER_MAX_W'(req_wdata), DATA_W)), req_wdata} ^ inj_mask;
  assign host_rd_c    = req_valid & ~req_we;
  assign scrub_chk_c  = (state == S_SCAN) & ~req_valid;
  assign host_trig_c  = host_rd_c & host_err_c;
  assign scrub_trig_c = scrub_chk_c & scrub_err_c;

  berger_zero_chk #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_host_chk (
    .data  (host_word[DATA_W-1:0]),
    .chk   (host_word[WORD_W-1:DATA_W]),
    .err_c (host_err_c)
  );

  berger_zero_chk #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_scrub_chk (
    .data  (scrub_word[DATA_W-1:0]),
    .chk   (scrub_word[WORD_W-1:DATA_W]),
    .err_c (scrub_err_c)
  );

  // Storage: reset to the legal all-zero codeword, written on host writes only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RST_WORD;
    end else if (req_valid && req_we) begin
      mem[req_addr] <= wr_word_c;
    end
  end

  // Host read response, one cycle after the request; holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= host_rd_c;
      if (host_rd_c) begin
        rsp_rdata <= host_word[DATA_W-1:0];
        rsp_err   <= host_err_c;
      end
    end
  end

  // Scrub sequencer: walks every location on host-idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      scrub_ptr  <= '0;
      scrub_busy <= 1'b0;
      scrub_done <= 1'b0;
    end else begin
      scrub_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (scrub_start) begin
            state      <= S_SCAN;
            scrub_ptr  <= '0;
            scrub_busy <= 1'b1;
          end
        end
        S_SCAN: begin
          if (!req_valid) begin
            if (scrub_ptr == PTR_LAST) begin
              state      <= S_DONE;
              scrub_ptr  <= '0;
              scrub_busy <= 1'b0;
              scrub_done <= 1'b1;
            end else begin
              scrub_ptr <= scrub_ptr + ADDR_W'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Error log; a fresh error in the clear cycle restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt  <= '0;
      err_addr <= '0;
      err_src  <= 1'b0;
      err_irq  <= 1'b0;
    end else if (host_trig_c || scrub_trig_c) begin
      err_irq  <= 1'b1;
      err_src  <= scrub_trig_c;
      err_addr <= scrub_trig_c ? scrub_ptr : req_addr;
      if (err_clr) begin
        err_cnt <= CNT_W'(1);
      end else if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end else if (err_clr) begin
      err_cnt <= '0;
      err_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_berger_zero_scrub.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural memory model.
module tb_mem_berger_zero_scrub;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CHK_W  = 4;
  localparam int CNT_W  = 8;
  localparam int WORD_W = DATA_W + CHK_W;
  localparam int CNT_MAX = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid, req_we, scrub_start, err_clr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [WORD_W-1:0] inj_mask;
  logic              rsp_valid, rsp_err, scrub_busy, scrub_done, err_src, err_irq;
  logic [DATA_W-1:0] rsp_rdata;
  logic [CNT_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] err_addr;

  mem_berger_zero_scrub #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CHK_W(CHK_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .inj_mask(inj_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .scrub_start(scrub_start), .scrub_busy(scrub_busy), .scrub_done(scrub_done),
    .err_cnt(err_cnt), .err_addr(err_addr), .err_src(err_src), .err_irq(err_irq),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Behavioural model state: expected outputs after the next clock edge.
  logic [WORD_W-1:0] m_mem [DEPTH];
  bit                e_rv, e_re, e_busy, e_done, e_irq, e_src;
  logic [DATA_W-1:0] e_rd;
  bit                scan_on;
  int                scan_idx, e_cnt, e_addr;
  int                n_chk, n_fail;

  function automatic bit word_bad(logic [WORD_W-1:0] w);
    return (DATA_W - $countones(w[DATA_W-1:0])) != int'(w[WORD_W-1:DATA_W]);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = {CHK_W'(DATA_W), DATA_W'(0)};
    e_rv = 0; e_re = 0; e_rd = '0; e_busy = 0; e_done = 0; e_irq = 0; e_src = 0;
    scan_on = 0; scan_idx = 0; e_cnt = 0; e_addr = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit herr, serr, was_done;
    int saddr;
    herr = 0; serr = 0; saddr = 0;
    if (req_valid && !req_we) begin
      e_rv = 1;
      e_rd = m_mem[req_addr][DATA_W-1:0];
      e_re = word_bad(m_mem[req_addr]);
      herr = e_re;
    end else begin
      e_rv = 0;
    end
    was_done = e_done;
    e_done = 0;
    if (scan_on) begin
      if (!req_valid) begin
        serr  = word_bad(m_mem[scan_idx]);
        saddr = scan_idx;
        scan_idx++;
        if (scan_idx == DEPTH) begin
          scan_on = 0;
          e_done  = 1;
        end
      end
    end else if (!was_done && scrub_start) begin
      scan_on  = 1;
      scan_idx = 0;
    end
    e_busy = scan_on;
    if (herr || serr) begin
      e_cnt  = err_clr ? 1 : (e_cnt < CNT_MAX ? e_cnt + 1 : CNT_MAX);
      e_irq  = 1;
      e_src  = serr;
      e_addr = serr ? saddr : int'(req_addr);
    end else if (err_clr) begin
      e_cnt = 0;
      e_irq = 0;
    end
    if (req_valid && req_we)
      m_mem[req_addr] = {CHK_W'(DATA_W - $countones(req_wdata)), req_wdata} ^ inj_mask;
  endtask

  task automatic compare();
    chk("rsp_valid",  32'(rsp_valid),  32'(e_rv));
    chk("rsp_rdata",  32'(rsp_rdata),  32'(e_rd));
    chk("rsp_err",    32'(rsp_err),    32'(e_re));
    chk("scrub_busy", 32'(scrub_busy), 32'(e_busy));
    chk("scrub_done", 32'(scrub_done), 32'(e_done));
    chk("err_cnt",    32'(err_cnt),    32'(e_cnt));
    chk("err_addr",   32'(err_addr),   32'(e_addr));
    chk("err_src",    32'(err_src),    32'(e_src));
    chk("err_irq",    32'(err_irq),    32'(e_irq));
  endtask

  task automatic drive(bit v, bit we, int a, logic [DATA_W-1:0] d, logic [WORD_W-1:0] m,
                       bit ss, bit clr);
    req_valid = v; req_we = we; req_addr = ADDR_W'(a); req_wdata = d;
    inj_mask = m; scrub_start = ss; err_clr = clr;
  endtask

  // Drive one cycle of inputs, then check every output against the model.
  task automatic step(bit v, bit we, int a, logic [DATA_W-1:0] d, logic [WORD_W-1:0] m,
                      bit ss, bit clr);
    drive(v, we, a, d, m, ss, clr);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  saw_done;
    n_chk = 0; n_fail = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid",  32'(rsp_valid),  0);
    chk("reset_scrub_busy", 32'(scrub_busy), 0);
    chk("reset_err_cnt",    32'(err_cnt),    0);
    chk("reset_err_irq",    32'(err_irq),    0);
    rst = 0;

    // Reset content reads back as a clean zero word.
    step(1, 0, 3, 0, 0, 0, 0);
    chk("rd3_valid", 32'(rsp_valid), 1);
    chk("rd3_data",  32'(rsp_rdata), 0);
    chk("rd3_err",   32'(rsp_err),   0);
    chk("rd3_cnt",   32'(err_cnt),   0);

    step(1, 1, 5, 8'hA5, 0, 0, 0);
    step(1, 0, 5, 0, 0, 0, 0);
    chk("rd5_valid", 32'(rsp_valid), 1);
    chk("rd5_data",  32'(rsp_rdata), 32'h A5);
    chk("rd5_err",   32'(rsp_err),   0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rd5_one_cycle", 32'(rsp_valid), 0);
    chk("rd5_hold",      32'(rsp_rdata), 32'h A5);

    // Data-bit injection seen on a host read.
    step(1, 1, 9, 8'h0F, 12'h001, 0, 0);
    step(1, 0, 9, 0, 0, 0, 0);
    chk("rd9_data", 32'(rsp_rdata), 32'h0E);
    chk("rd9_err",  32'(rsp_err),   1);
    chk("rd9_cnt",  32'(err_cnt),   1);
    chk("rd9_addr", 32'(err_addr),  9);
    chk("rd9_src",  32'(err_src),   0);
    chk("rd9_irq",  32'(err_irq),   1);

    // Repair addr 9, clear, corrupt check bits of 2 and 14, then scrub with no traffic.
    step(1, 1, 9, 8'h0F, 0, 0, 1);
    chk("clr_cnt", 32'(err_cnt), 0);
    step(1, 1, 2, 8'h33, 12'h100, 0, 0);
    step(1, 1, 14, 8'h7E, 12'h100, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    cyc = 1;
    while (!scrub_done && cyc < 100) begin
      step(0, 0, 0, 0, 0, 0, 0);
      cyc++;
    end
    chk("scrub1_cycles", 32'(cyc),      17);
    chk("scrub1_cnt",    32'(err_cnt),  2);
    chk("scrub1_addr",   32'(err_addr), 14);
    chk("scrub1_src",    32'(err_src),  1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Scrub interleaved with host reads every other cycle.
    step(0, 0, 0, 0, 0, 1, 0);
    cyc = 1;
    while (!scrub_done && cyc < 200) begin
      if (cyc % 2 == 1) step(1, 0, int'($urandom_range(0, DEPTH - 1)), 0, 0, 0, 0);
      else              step(0, 0, 0, 0, 0, 0, 0);
      cyc++;
    end
    chk("scrub2_cycles", 32'(cyc), 33);
    step(0, 0, 0, 0, 0, 0, 0);

    // Counter saturation and clear priority.
    for (int i = 0; i < 300; i++) step(1, 0, 2, 0, 0, 0, 0);
    chk("sat_cnt", 32'(err_cnt), CNT_MAX);
    step(1, 0, 2, 0, 0, 0, 1);
    chk("clr_err_cnt", 32'(err_cnt), 1);
    chk("clr_err_irq", 32'(err_irq), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("clr_only_cnt", 32'(err_cnt), 0);
    chk("clr_only_irq", 32'(err_irq), 0);
    chk("clr_keep_addr", 32'(err_addr), 2);

    // Reset in the middle of a pass aborts it without a done pulse.
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1;
    #1;
    chk("midrst_busy", 32'(scrub_busy), 0);
    chk("midrst_done", 32'(scrub_done), 0);
    chk("midrst_cnt",  32'(err_cnt),    0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      saw_done |= scrub_done;
    end
    chk("midrst_no_done", 32'(saw_done), 0);
    step(1, 0, 2, 0, 0, 0, 0);
    chk("midrst_mem_clean", 32'(rsp_err), 0);

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      bit                v, we, ss, clr;
      logic [WORD_W-1:0] m;
      v   = 1'($urandom_range(0, 1));
      we  = ($urandom_range(0, 2) == 0);
      ss  = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 29) == 0);
      m   = ($urandom_range(0, 7) == 0) ? WORD_W'(32'd1 << $urandom_range(0, WORD_W - 1)) : '0;
      step(v, we, int'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom), m, ss, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_berger_zero_scrub.md
Name: mem_berger_zero_scrub

Overview:
- Parametrised Berger-protected register-file memory. Check field = count of zero bits in the data word.
- Encodes check bits on write and verifies them on every host read.
- Runs an optional background scrub pass over all locations, using only host-idle cycles.
- Reports errors through a saturating counter, a last-error address/source log and a sticky interrupt. It sits between a host datapath and status/CSR logic.

Parameters:
- DATA_W, 8, data bits per word.
- DEPTH, 16, number of words; must be ≥2.
- ADDR_W, $clog2(DEPTH), address width.
- CHK_W, $clog2(DATA_W+1), Berger check width.
- CNT_W, 8, error counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  host access request
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  host address
- req_wdata  in  DATA_W  host write data
- inj_mask  in  DATA_W+CHK_W  XOR mask applied to the stored codeword on a write (fault injection; tie 0 in mission mode)
- rsp_valid  out  1  read data valid
- rsp_rdata  out  DATA_W  read data (data field only)
- rsp_err  out  1  read codeword failed check
- scrub_start  in  1  pulse: begin one full scrub pass
- scrub_busy  out  1  pass in progress
- scrub_done  out  1  one-cycle pulse at end of pass
- err_cnt  out  CNT_W  saturating count of detected errors
- err_addr  out  ADDR_W  address of most recent error
- err_src  out  1  source of most recent error: 0=host, 1=scrub
- err_irq  out  1  sticky error flag
- err_clr  in  1  clears err_irq and err_cnt

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- Reset values:
  - Every location = valid codeword {CHK_W'(DATA_W), DATA_W'0}; the all-zero word is illegal.
  - All outputs 0; FSM in S_IDLE; scrub_ptr = 0.
- Encoding: stored word = {zeros(wdata), wdata} ^ inj_mask. The check field occupies the MSBs.
- Write: takes effect at the clock edge when req_valid & req_we. No response is generated.
- Read, latency 1:
  - req_valid & !req_we in cycle N gives rsp_valid = 1 in cycle N+1.
  - rsp_rdata = stored data field.
  - rsp_err = (zeros(stored data) != stored check).
  - rsp_valid is otherwise 0. rsp_rdata and rsp_err hold their last value while rsp_valid = 0.
- Read-during-write does not occur: single port, one request per cycle.
- Scrub FSM:
  - S_IDLE: scrub_start → S_SCAN, scrub_ptr = 0, scrub_busy = 1. scrub_start outside S_IDLE is ignored.
  - S_SCAN: in any cycle with req_valid = 0, check mem[scrub_ptr] combinationally and increment scrub_ptr. If req_valid = 1, stall; ptr holds and the host has priority.
  - S_SCAN → S_DONE: after location DEPTH-1 is checked.
  - S_DONE: scrub_done = 1 for one cycle, scrub_busy = 0, then → S_IDLE.
  - A scrub pass takes DEPTH+1 cycles with no host traffic.
- Scrub is detect-only; the memory contents are never modified.
- Error logging:
  - Triggers: rsp_err asserted on a host read response, or a scrub check failing.
  - On a trigger: err_cnt += 1, saturating at 2^CNT_W-1; err_addr/err_src updated; err_irq = 1.
  - Host and scrub errors cannot coincide, because scrub stalls whenever req_valid = 1.
- err_clr:
  - Zeroes err_cnt and err_irq next cycle. err_addr and err_src are kept.
  - If a new error occurs in the same cycle, the error wins: err_irq = 1, err_cnt = 1.
- Boundaries:
  - scrub_ptr wraps DEPTH-1 → 0 only via S_DONE/S_IDLE.
  - A host write to the location scrub_ptr is about to check is seen by the next scrub check.
  - rst mid-pass aborts the pass; no scrub_done pulse is produced.
- Width rules:
  - The zero count is computed at CHK_W bits.
  - Comparison is on the full CHK_W field.
  - Injected check-bit flips count as errors.

Decomposition:
- Package mem_berger_pkg:
  - function berger_zeros(data) returning the CHK_W-bit zero count.
  - scrub state enum {S_IDLE, S_SCAN, S_DONE}.
  - Function for the reset codeword.
- Sub-module berger_zero_chk (combinational): data in, check in → err out.
  - Instantiated twice: host read path and scrub path.

Test Plan:
- Reset then host read of addr 3 (DATA_W=8) → cycle+1 rsp_valid=1, rsp_rdata=0x00, rsp_err=0; err_cnt=0.
- Write 0xA5 to addr 5 (check=4), read addr 5 → rsp_rdata=0xA5, rsp_err=0, latency exactly 1 cycle.
- Write 0x0F to addr 9 with inj_mask=0x001 (data bit0 flipped), read addr 9 → rsp_rdata=0x0E, rsp_err=1, err_cnt=1, err_addr=9, err_src=0, err_irq=1.
- Corrupt addrs 2 and 14 via inj_mask=0x100 (check bit), pulse scrub_start with no traffic → scrub_done after 17 cycles, err_cnt=2, err_addr=14, err_src=1.
- Scrub pass with host reads every other cycle → scrub stalls on busy cycles, pass completes in 33 cycles (DEPTH=16), all host responses correct.
- Drive 300 errors with CNT_W=8 → err_cnt saturates at 255. Then err_clr in the same cycle as a new error → err_cnt=1, err_irq=1. A later err_clr alone → err_cnt=0, err_irq=0.
